// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply
// and restoring divide over DATA_WIDTH cycles, stalling the pipeline while busy.
module ex_muldiv #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_flush,
    output logic                  o_stall,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);
    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONES    = '1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nxt;

    logic [2:0]           op_q;
    logic                 neg_a_q, neg_b_q;
    logic [W-1:0]         b_q;
    // Shared accumulator: multiply keeps {hi, lo} product, divide keeps {remainder, quotient}.
    logic [2*W-1:0]       acc;
    logic [CNT_WIDTH-1:0] cnt;

    logic           a_signed, b_signed, sa, sb;
    logic [W-1:0]   abs_a, abs_b;
    logic           div_zero, div_ovf, special;
    logic [W-1:0]   special_res;
    logic           go;

    always_comb begin
        a_signed    = i_op[2] ? ~i_op[0] : (i_op[1:0] != 2'b11);
        b_signed    = i_op[2] ? ~i_op[0] : ~i_op[1];
        sa          = a_signed & i_a[W-1];
        sb          = b_signed & i_b[W-1];
        abs_a       = sa ? -i_a : i_a;
        abs_b       = sb ? -i_b : i_b;
        div_zero    = i_op[2] & (i_b == '0);
        div_ovf     = i_op[2] & ~i_op[0] & (i_a == MIN_VAL) & (i_b == ONES);
        special     = div_zero | div_ovf;
        special_res = div_zero ? (i_op[1] ? i_a : ONES) : (i_op[1] ? '0 : MIN_VAL);
        go          = (state == IDLE) & i_start & ~i_flush;
    end

    logic [W:0]     mul_sum, div_shift, div_diff;
    logic [2*W-1:0] mul_next, div_next, prod;
    logic [W-1:0]   quo_s, rem_s, fix_res;

    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_q} : '0);
        mul_next  = {mul_sum, acc[W-1:1]};
        div_shift = {acc[2*W-1:W], acc[W-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_next  = div_diff[W] ? {div_shift[W-1:0], acc[W-2:0], 1'b0}
                                : {div_diff[W-1:0],  acc[W-2:0], 1'b1};
        prod      = (neg_a_q ^ neg_b_q) ? -acc : acc;
        quo_s     = (neg_a_q ^ neg_b_q) ? -acc[W-1:0] : acc[W-1:0];
        rem_s     = neg_a_q ? -acc[2*W-1:W] : acc[2*W-1:W];
        case (op_q)
            3'b000:               fix_res = prod[W-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*W-1:W];
            3'b100, 3'b101:       fix_res = quo_s;
            default:              fix_res = rem_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (go) state_nxt = special ? DONE : CALC;
            CALC: if (cnt == LAST_CNT) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (i_flush) state_nxt = IDLE;
    end

    assign o_busy  = (state == CALC) | (state == FIX);
    assign o_stall = go | (o_busy & ~i_flush);
    assign o_done  = (state == DONE) & ~i_flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_q      <= '0;
            acc      <= '0;
            cnt      <= '0;
            o_result <= '0;
        end else if (!i_flush) begin
            case (state)
                IDLE: if (i_start) begin
                    op_q    <= i_op;
                    neg_a_q <= sa;
                    neg_b_q <= sb;
                    b_q     <= abs_b;
                    acc     <= {{W{1'b0}}, abs_a};
                    cnt     <= '0;
                    if (special) o_result <= special_res;
                end
                CALC: begin
                    acc <= op_q[2] ? div_next : mul_next;
                    cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
                end
                FIX: o_result <= fix_res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: checks results, latency, stall/done timing, flush and reset.
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst_n, i_start, i_flush;
    logic [2:0]  i_op;
    logic [31:0] i_a, i_b;
    logic        o_stall, o_busy, o_done;
    logic [31:0] o_result;

    int tests = 0;
    int fails = 0;

    ex_muldiv #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_op(i_op), .i_a(i_a), .i_b(i_b),
        .i_flush(i_flush), .o_stall(o_stall), .o_busy(o_busy), .o_done(o_done),
        .o_result(o_result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after the edge that opens the start cycle T.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int n;
        logic bad;
        logic [31:0] res;
        i_op = op; i_a = a; i_b = b; i_start = 1'b1;
        @(negedge clk);
        check({tag, "_stall_start"}, {31'b0, o_stall}, 32'd1);
        @(posedge clk); #1;
        i_start = 1'b0; i_a = $urandom; i_b = $urandom;
        n = 0; bad = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (!o_done && (o_stall !== 1'b1 || o_busy !== 1'b1)) bad = 1'b1;
        end while (!o_done && n < 60);
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_result"}, o_result, exp);
        check({tag, "_stall_calc"}, {31'b0, bad}, 32'd0);
        check({tag, "_stall_done"}, {31'b0, o_stall}, 32'd0);
        res = o_result;
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'b0, o_done}, 32'd0);
        check({tag, "_hold"}, o_result, res);
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0; i_start = 1'b0; i_flush = 1'b0; i_op = '0; i_a = '0; i_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result", o_result, 32'd0);
        check("rst_flags", {29'b0, o_done, o_busy, o_stall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        @(posedge clk); #1; do_op("mul",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        @(posedge clk); #1; do_op("mulh",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        @(posedge clk); #1; do_op("mulhu",    3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        @(posedge clk); #1; do_op("mulhsu",   3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34);
        @(posedge clk); #1; do_op("mulhu_max",3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        @(posedge clk); #1; do_op("mul_max",  3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34);
        @(posedge clk); #1; do_op("div",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
        @(posedge clk); #1; do_op("rem",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
        @(posedge clk); #1; do_op("divu",     3'b101, 32'd100,      32'd7,        32'd14,       34);
        @(posedge clk); #1; do_op("remu",     3'b111, 32'd100,      32'd7,        32'd2,        34);
        @(posedge clk); #1; do_op("divu_z",   3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF, 1);
        @(posedge clk); #1; do_op("rem_z",    3'b110, 32'h1234,     32'd0,        32'h00001234, 1);
        @(posedge clk); #1; do_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        @(posedge clk); #1; do_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        @(posedge clk); #1; do_op("mul_prev", 3'b000, 32'd9,        32'd11,       32'd99,       34);

        // Flush a MUL in its 10th CALC cycle; result must stay 99.
        @(posedge clk); #1;
        i_op = 3'b000; i_a = 32'd3; i_b = 32'd5; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (o_done) seen = 1'b1;
            @(posedge clk); #1;
        end
        i_flush = 1'b1;
        @(negedge clk);
        check("flush_stall", {31'b0, o_stall}, 32'd0);
        check("flush_done", {31'b0, o_done | seen}, 32'd0);
        @(posedge clk); #1;
        i_flush = 1'b0;
        check("flush_idle", {31'b0, o_busy}, 32'd0);
        check("flush_result", o_result, 32'd99);
        do_op("mul_after_flush", 3'b000, 32'd6, 32'd7, 32'd42, 34);

        // Synchronous reset in the middle of a DIV.
        @(posedge clk); #1;
        i_op = 3'b100; i_a = 32'd100; i_b = 32'd7; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_result", o_result, 32'd0);
        check("midrst_flags", {29'b0, o_done, o_busy, o_stall}, 32'd0);
        @(posedge clk); #1; do_op("divu_after_rst", 3'b101, 32'd100, 32'd7, 32'd14, 34);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
